// File: rtl/apb3_slot_mux_tmo.sv
// APB3 one-to-N slot decoder and response mux. A stalled slot is cut off
// after TMO_CYCLES access cycles with an error response. The first
// offending slot and a saturating event count are kept as sticky status.
module apb3_slot_mux_tmo #(
  parameter int unsigned APB_DWIDTH = 32,
  parameter int unsigned NUM_SLOTS  = 3,
  parameter logic [15:0] SLOT_EN    = 16'h0007,
  parameter int unsigned SLOT_LSB   = 16,
  parameter logic [15:0] TMO_CYCLES = 16'd255
) (
  input  logic                            PCLK,
  input  logic                            PRESET,
  input  logic                            PSEL,
  input  logic                            PENABLE,
  input  logic                            PWRITE,
  input  logic [31:0]                     PADDR,
  input  logic [APB_DWIDTH-1:0]           PWDATA,
  output logic [APB_DWIDTH-1:0]           PRDATA,
  output logic                            PREADY,
  output logic                            PSLVERR,
  output logic [NUM_SLOTS-1:0]            PSELS,
  output logic [31:0]                     PADDRS,
  output logic                            PENABLES,
  output logic                            PWRITES,
  output logic [APB_DWIDTH-1:0]           PWDATAS,
  input  logic [NUM_SLOTS*APB_DWIDTH-1:0] PRDATAS,
  input  logic [NUM_SLOTS-1:0]            PREADYS,
  input  logic [NUM_SLOTS-1:0]            PSLVERRS,
  input  logic                            TMO_CLR,
  output logic                            TMO_FLAG,
  output logic [3:0]                      TMO_SLOT,
  output logic [7:0]                      TMO_CNT
);

  typedef enum logic [1:0] {StIdle, StAccess, StTerm} state_e;

  // Keeps only the slot-local address bits below SLOT_LSB.
  localparam logic [31:0] LocalMask = (32'd1 << SLOT_LSB) - 32'd1;

  state_e      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        tmo_flag_q, tmo_flag_d;
  logic [3:0]  tmo_slot_q, tmo_slot_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;

  logic [3:0]            slot;
  logic                  mapped;
  logic                  slv_ready;
  logic                  slv_err;
  logic [APB_DWIDTH-1:0] slv_rdata;
  logic                  tmo_fire;

  assign slot     = PADDR[SLOT_LSB+3:SLOT_LSB];
  assign PADDRS   = PADDR & LocalMask;
  assign PWRITES  = PWRITE;
  assign PWDATAS  = PWDATA;
  assign PENABLES = PENABLE;

  // Slot decode and response select; the loop bound keeps every index inside NUM_SLOTS.
  always_comb begin
    mapped    = 1'b0;
    slv_ready = 1'b0;
    slv_err   = 1'b0;
    slv_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (slot == 4'(i)) begin
        mapped    = SLOT_EN[i];
        slv_ready = PREADYS[i];
        slv_err   = PSLVERRS[i];
        slv_rdata = PRDATAS[i*APB_DWIDTH +: APB_DWIDTH];
      end
    end
  end

  // A ready slave on the limit cycle wins over the timeout.
  assign tmo_fire = (TMO_CYCLES != 16'd0) && PSEL && PENABLE && (state_q == StAccess) &&
                    mapped && !slv_ready && (wait_q == TMO_CYCLES - 16'd1);

  // Per-slot select; never during the cut-off cycle or while in reset.
  always_comb begin
    PSELS = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      PSELS[i] = PSEL && mapped && (slot == 4'(i)) && (state_q != StTerm) && !PRESET;
    end
  end

  // Master-side response; reset forces the idle response.
  always_comb begin
    PRDATA  = '0;
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    if (!PRESET) begin
      unique case (state_q)
        StAccess: begin
          if (mapped) begin
            PRDATA  = slv_rdata;
            PREADY  = slv_ready;
            PSLVERR = slv_err;
          end else begin
            PSLVERR = 1'b1;
          end
        end
        StTerm:  PSLVERR = 1'b1;
        default: ;
      endcase
    end
  end

  // Next state, wait counter and sticky timeout status.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    tmo_flag_d = tmo_flag_q;
    tmo_slot_d = tmo_slot_q;
    tmo_cnt_d  = tmo_cnt_q;

    unique case (state_q)
      StIdle:   if (PSEL && !PENABLE) state_d = StAccess;
      StAccess: begin
        if (tmo_fire)    state_d = StTerm;
        else if (PREADY) state_d = StIdle;
      end
      StTerm:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (!PSEL) state_d = StIdle;

    if (state_q == StIdle && state_d == StAccess) begin
      wait_d = '0;
    end else if (state_q == StAccess && PENABLE && mapped && !slv_ready &&
                 wait_q != 16'hFFFF) begin
      wait_d = wait_q + 16'd1;
    end

    if (tmo_fire) begin
      tmo_flag_d = 1'b1;
      if (TMO_CLR) begin
        tmo_cnt_d  = 8'd1;
        tmo_slot_d = slot;
      end else begin
        if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
        if (!tmo_flag_q)        tmo_slot_d = slot;
      end
    end else if (TMO_CLR) begin
      tmo_flag_d = 1'b0;
      tmo_slot_d = '0;
      tmo_cnt_d  = '0;
    end
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      tmo_flag_q <= 1'b0;
      tmo_slot_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      tmo_flag_q <= tmo_flag_d;
      tmo_slot_q <= tmo_slot_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign TMO_FLAG = tmo_flag_q;
  assign TMO_SLOT = tmo_slot_q;
  assign TMO_CNT  = tmo_cnt_q;

endmodule

// File: tb/tb_apb3_slot_mux_tmo.sv
// Bench for apb3_slot_mux_tmo: decode table, directed transfer sequences
// and random transfers scored against a transaction-level model.
module tb_apb3_slot_mux_tmo;

  logic PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  logic        PRESET, PSEL, PENABLE, PWRITE, TMO_CLR;
  logic [31:0] PADDR, PWDATA;

  // Main DUT: 3 slots, bit 3 of the enable mask set but outside NUM_SLOTS, timeout 4.
  logic [31:0] prdata, paddrs, pwdatas;
  logic        pready, pslverr, penables, pwrites, tmo_flag;
  logic [2:0]  psels, PREADYS, PSLVERRS;
  logic [95:0] PRDATAS;
  logic [3:0]  tmo_slot;
  logic [7:0]  tmo_cnt;

  // Second DUT: 16-bit data, 4 slots with 1 and 3 disabled, timeout disabled.
  logic [15:0] prdata2, pwdatas2;
  logic        pready2, pslverr2, penables2, pwrites2, tmo_flag2;
  logic [3:0]  psels2, PREADYS2, tmo_slot2;
  logic [31:0] paddrs2;
  logic [63:0] PRDATAS2;
  logic [7:0]  tmo_cnt2;

  apb3_slot_mux_tmo #(
    .APB_DWIDTH(32), .NUM_SLOTS(3), .SLOT_EN(16'h000F), .SLOT_LSB(16), .TMO_CYCLES(16'd4)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .PSELS(psels), .PADDRS(paddrs), .PENABLES(penables), .PWRITES(pwrites),
    .PWDATAS(pwdatas), .PRDATAS(PRDATAS), .PREADYS(PREADYS), .PSLVERRS(PSLVERRS),
    .TMO_CLR(TMO_CLR), .TMO_FLAG(tmo_flag), .TMO_SLOT(tmo_slot), .TMO_CNT(tmo_cnt)
  );

  apb3_slot_mux_tmo #(
    .APB_DWIDTH(16), .NUM_SLOTS(4), .SLOT_EN(16'h0005), .SLOT_LSB(8), .TMO_CYCLES(16'd0)
  ) dut2 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA[15:0]), .PRDATA(prdata2), .PREADY(pready2),
    .PSLVERR(pslverr2), .PSELS(psels2), .PADDRS(paddrs2), .PENABLES(penables2),
    .PWRITES(pwrites2), .PWDATAS(pwdatas2), .PRDATAS(PRDATAS2), .PREADYS(PREADYS2),
    .PSLVERRS(4'b0000), .TMO_CLR(1'b0), .TMO_FLAG(tmo_flag2), .TMO_SLOT(tmo_slot2),
    .TMO_CNT(tmo_cnt2)
  );

  localparam logic [15:0] SlotEn = 16'h000F;
  localparam int          NumSlots = 3;
  localparam int          TmoLimit = 4;

  int errors = 0;
  int checks = 0;

  // Expected sticky status.
  logic       m_flag;
  logic [3:0] m_slot;
  logic [7:0] m_cnt;

  typedef struct {
    logic        psel;
    logic [31:0] addr;
    logic [2:0]  sel1;
    logic [31:0] a1;
    logic [3:0]  sel2;
    logic [31:0] a2;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic model_clr();
    m_flag = 1'b0;
    m_slot = 4'd0;
    m_cnt  = 8'd0;
  endtask

  task automatic model_tmo(input logic [3:0] s, input logic clr);
    if (clr) begin
      m_cnt  = 8'd1;
      m_slot = s;
    end else begin
      if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      if (!m_flag) m_slot = s;
    end
    m_flag = 1'b1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_flag"}, tmo_flag, m_flag);
    check({tag, "_slot"}, tmo_slot, m_slot);
    check({tag, "_cnt"}, tmo_cnt, m_cnt);
  endtask

  // Random data on every slot; the addressed slot gets the given response.
  task automatic drive_slaves(input logic [3:0] slot, input logic rdy, input logic err,
                              input logic [31:0] rdata);
    int idx;
    PRDATAS  = {$urandom(), $urandom(), $urandom()};
    PREADYS  = 3'($urandom());
    PSLVERRS = 3'($urandom());
    if (slot < 4'(NumSlots)) begin
      idx = int'(slot);
      PRDATAS[idx*32 +: 32]  = rdata;
      PREADYS[slot[1:0]]     = rdy;
      PSLVERRS[slot[1:0]]    = err;
    end
  endtask

  // One APB transfer; the slave asserts ready from access cycle 'lat' on.
  // clr_k >= 0 pulses TMO_CLR during that access cycle.
  task automatic do_xfer(input logic [11:0] hi, input logic [3:0] slot, input logic [15:0] off,
                         input logic wr, input int lat, input logic err,
                         input logic [31:0] rdata, input int clr_k);
    logic        is_map, will_tmo, done;
    logic [2:0]  exp_sel, e_sel;
    logic        e_rdy, e_err;
    logic [31:0] e_data;
    is_map   = (slot < 4'(NumSlots)) && SlotEn[slot];
    will_tmo = is_map && (lat >= TmoLimit);
    exp_sel  = is_map ? (3'b001 << slot) : 3'b000;
    done     = 1'b0;
    PSEL     = 1'b1;
    PENABLE  = 1'b0;
    PWRITE   = wr;
    PADDR    = {hi, slot, off};
    PWDATA   = $urandom();
    TMO_CLR  = 1'b0;
    drive_slaves(slot, 1'b0, err, rdata);
    settle();
    check("setup_psels", psels, exp_sel);
    check("setup_paddrs", paddrs, {16'h0, off});
    check("setup_resp", {pready, pslverr, prdata}, {1'b1, 1'b0, 32'h0});
    check("setup_fwd", {penables, pwrites, pwdatas}, {1'b0, wr, PWDATA});
    tick();
    PENABLE = 1'b1;
    for (int k = 0; k < 12 && !done; k++) begin
      drive_slaves(slot, (k >= lat), err, rdata);
      TMO_CLR = (k == clr_k);
      settle();
      if (!is_map || (will_tmo && k == TmoLimit)) begin
        e_rdy = 1'b1; e_err = 1'b1; e_data = 32'h0; e_sel = 3'b000;
      end else begin
        e_rdy = (k >= lat); e_err = err; e_data = rdata; e_sel = exp_sel;
      end
      check("acc_psels", psels, e_sel);
      check("acc_resp", {pready, pslverr, prdata}, {e_rdy, e_err, e_data});
      if (will_tmo && k == TmoLimit - 1) model_tmo(slot, k == clr_k);
      else if (k == clr_k) model_clr();
      done = e_rdy;
      tick();
    end
    TMO_CLR = 1'b0;
    check_status("st");
  endtask

  task automatic idle(input int n);
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    TMO_CLR = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_clr();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    TMO_CLR = 1'b1;
    tick();
    TMO_CLR = 1'b0;
    model_clr();
    check_status("clr");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h0001_0040, 3'b010, 32'h0000_0040, 4'b0001, 32'h0000_0040};
    vecs[1] = '{1'b1, 32'h0005_0000, 3'b000, 32'h0000_0000, 4'b0001, 32'h0000_0000};
    vecs[2] = '{1'b1, 32'h0003_1234, 3'b000, 32'h0000_1234, 4'b0100, 32'h0000_0034};
    vecs[3] = '{1'b0, 32'h0002_FFFF, 3'b000, 32'h0000_FFFF, 4'b0000, 32'h0000_00FF};
    vecs[4] = '{1'b1, 32'hFFF2_ABCD, 3'b100, 32'h0000_ABCD, 4'b0000, 32'h0000_00CD};
    vecs[5] = '{1'b1, 32'h0000_0000, 3'b001, 32'h0000_0000, 4'b0001, 32'h0000_0000};
    vecs[6] = '{1'b1, 32'h000F_8000, 3'b000, 32'h0000_8000, 4'b0001, 32'h0000_0000};
    vecs[7] = '{1'b1, 32'h1230_0104, 3'b001, 32'h0000_0104, 4'b0000, 32'h0000_0004};
    vecs[8] = '{1'b1, 32'h0002_0300, 3'b100, 32'h0000_0300, 4'b0000, 32'h0000_0000};

    model_clr();
    PRESET   = 1'b1;
    PSEL     = 1'b1;
    PENABLE  = 1'b0;
    PWRITE   = 1'b0;
    PADDR    = 32'h0001_0040;
    PWDATA   = 32'h0;
    TMO_CLR  = 1'b0;
    PRDATAS  = '0;
    PREADYS  = 3'b111;
    PSLVERRS = 3'b000;
    PRDATAS2 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    PREADYS2 = 4'hF;

    // Reset: selects held low, idle response, status cleared.
    tick();
    tick();
    settle();
    check("rst_psels", psels, 3'b000);
    check("rst_psels2", psels2, 4'b0000);
    check("rst_resp", {pready, pslverr, prdata}, {1'b1, 1'b0, 32'h0});
    check("rst_paddrs", paddrs, 32'h0000_0040);
    PRESET = 1'b0;
    PSEL   = 1'b0;
    tick();
    check_status("rst");

    // Decode table; PENABLE held high so the FSM stays idle.
    for (int i = 0; i < 9; i++) begin
      PSEL    = vecs[i].psel;
      PENABLE = 1'b1;
      PADDR   = vecs[i].addr;
      PWRITE  = 1'($urandom());
      PWDATA  = $urandom();
      settle();
      check("dec_psels", psels, vecs[i].sel1);
      check("dec_paddrs", paddrs, vecs[i].a1);
      check("dec_resp", {pready, pslverr, prdata}, {1'b1, 1'b0, 32'h0});
      check("dec_fwd", {penables, pwrites, pwdatas}, {1'b1, PWRITE, PWDATA});
      check("dec_psels2", psels2, vecs[i].sel2);
      check("dec_paddrs2", paddrs2, vecs[i].a2);
      check("dec_pwdatas2", pwdatas2, PWDATA[15:0]);
      tick();
    end
    idle(1);

    // Mapped read of slot 1, two cycles.
    do_xfer(12'h000, 4'd1, 16'h0040, 1'b0, 0, 1'b0, 32'hA5A5_0001, -1);
    // Unmapped slot 5.
    do_xfer(12'h000, 4'd5, 16'h0000, 1'b0, 0, 1'b0, 32'h0, -1);
    idle(1);
    // Timeout on slot 2.
    do_xfer(12'h000, 4'd2, 16'h0010, 1'b0, 10, 1'b0, 32'h1111_2222, -1);
    check("t20_flag", tmo_flag, 1'b1);
    check("t20_slot", tmo_slot, 4'd2);
    check("t20_cnt", tmo_cnt, 8'd1);
    idle(1);
    // Ready on the limit cycle beats the timeout.
    do_xfer(12'h000, 4'd2, 16'h0010, 1'b0, 3, 1'b0, 32'h3333_4444, -1);
    check("race_cnt", {tmo_flag, tmo_cnt}, {1'b1, 8'd1});
    idle(1);
    // Second timeout keeps the first slot.
    do_xfer(12'h000, 4'd0, 16'h0020, 1'b1, 9, 1'b0, 32'h0, -1);
    check("sticky_slot", tmo_slot, 4'd2);
    check("sticky_cnt", tmo_cnt, 8'd2);
    pulse_clr();
    check("clr_all", {tmo_flag, tmo_slot, tmo_cnt}, 13'h0);
    // Clear coinciding with a timeout: the timeout wins and restarts the count.
    do_xfer(12'h000, 4'd0, 16'h0, 1'b0, 9, 1'b0, 32'h0, -1);
    do_xfer(12'h000, 4'd0, 16'h0, 1'b0, 9, 1'b0, 32'h0, -1);
    do_xfer(12'h000, 4'd1, 16'h0, 1'b0, 9, 1'b0, 32'h0, 3);
    check("clr_race", {tmo_flag, tmo_slot, tmo_cnt}, {1'b1, 4'd1, 8'd1});
    pulse_clr();

    // Saturation of the event count.
    for (int n = 0; n < 300; n++) begin
      do_xfer(12'h000, 4'(n % 3), 16'h0, 1'b0, 8, 1'b0, 32'h0, -1);
    end
    check("sat_cnt", tmo_cnt, 8'd255);
    check("sat_slot", tmo_slot, 4'd0);
    pulse_clr();

    // Random transfers, back-to-back or with idle gaps.
    for (int t = 0; t < 150; t++) begin
      logic [3:0] s;
      int         ck;
      s  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
      ck = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      do_xfer(12'($urandom()), s, 16'($urandom()), 1'($urandom()), int'($urandom_range(0, 6)),
              1'($urandom()), $urandom(), ck);
      if ($urandom_range(0, 9) == 0) pulse_clr();
      else idle(int'($urandom_range(0, 2)));
    end
    idle(1);

    // Reset during the second wait cycle of a stalled slot-1 access.
    do_xfer(12'h000, 4'd0, 16'h0, 1'b0, 9, 1'b0, 32'h0, -1);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = 32'h0001_0008;
    drive_slaves(4'd1, 1'b0, 1'b0, 32'h1234_5678);
    tick();
    PENABLE = 1'b1;
    drive_slaves(4'd1, 1'b0, 1'b0, 32'h1234_5678);
    settle();
    check("mrst_wait1", {pready, psels}, {1'b0, 3'b010});
    tick();
    PRESET = 1'b1;
    settle();
    check("mrst_psels", psels, 3'b000);
    check("mrst_resp", {pready, pslverr, prdata}, {1'b1, 1'b0, 32'h0});
    tick();
    PRESET = 1'b0;
    model_clr();
    check("mrst_flag", tmo_flag, 1'b0);
    settle();
    check("mrst_idle_resp", {pready, pslverr, prdata}, {1'b1, 1'b0, 32'h0});
    check("mrst_idle_psels", psels, 3'b010);
    repeat (6) tick();
    check("mrst_no_tmo", {tmo_flag, tmo_cnt}, 9'h0);
    idle(1);
    do_xfer(12'h000, 4'd0, 16'h0010, 1'b1, 1, 1'b0, 32'hCAFE_0000, -1);
    idle(1);

    // Disabled timeout: the second DUT waits indefinitely on a stalled slot.
    PRDATAS2 = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
    PREADYS2 = 4'h0;
    PSEL     = 1'b1;
    PENABLE  = 1'b0;
    PADDR    = 32'h0007_0200;
    drive_slaves(4'd7, 1'b0, 1'b0, 32'h0);
    tick();
    PENABLE = 1'b1;
    settle();
    check("nt_dut1_unmapped", {pready, pslverr, prdata}, {1'b1, 1'b1, 32'h0});
    check("nt_wait_first", pready2, 1'b0);
    repeat (300) tick();
    settle();
    check("nt_wait_long", {pready2, psels2}, {1'b0, 4'b0100});
    check("nt_no_flag", {tmo_flag2, tmo_cnt2}, 9'h0);
    check("nt_dut1_idle", {pready, pslverr}, {1'b1, 1'b0});
    check_status("nt");
    PREADYS2 = 4'b0100;
    settle();
    check("nt_done", {pready2, pslverr2, prdata2}, {1'b1, 1'b0, 16'hBEEF});
    tick();
    PREADYS2 = 4'hF;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
